// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scan driver.
// It latches a snapshot of the digit data, then scans one digit per slot.
// Each slot opens with an anti-ghost guard time. Per-digit blank, blink and
// leading-zero suppression are supported. an/seg are registered.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned GUARD       = 1000,
  parameter int unsigned BLINK_SLOTS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank_in,
  input  logic [7:0]  blink_in,
  input  logic        lz_en,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

  logic [PW-1:0] pcnt;
  logic [2:0]    idx;
  logic [BW-1:0] bcnt;
  logic          phase;

  logic [31:0]   dig_sh;
  logic [7:0]    dp_sh;
  logic [7:0]    blank_sh;
  logic [7:0]    blink_sh;
  logic          lz_sh;

  logic          tick;
  logic          in_guard;
  logic [3:0]    cur_code;
  logic [7:0]    cur_enc;
  logic [7:0]    supp;
  logic          zrun;
  logic          dark;

  // Slot tick and guard window from the prescaler
  always_comb begin
    tick     = (pcnt == PW'(SCAN_DIV - 1));
    in_guard = (pcnt < PW'(GUARD));
  end

  // Leading-zero suppression: digit k is suppressed when k and every digit above it are zero
  always_comb begin
    supp = '0;
    zrun = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      zrun = zrun & (dig_sh[4*k +: 4] == 4'd0);
      if (k != 0) supp[k] = lz_sh & zrun;
    end
  end

  // Segment encoding of the digit under scan; codes 10-15 show "E"
  always_comb begin
    cur_code = dig_sh[{idx, 2'b00} +: 4];
    case (cur_code)
      4'd0:    cur_enc = 8'hFC;
      4'd1:    cur_enc = 8'h60;
      4'd2:    cur_enc = 8'hDA;
      4'd3:    cur_enc = 8'hF2;
      4'd4:    cur_enc = 8'h66;
      4'd5:    cur_enc = 8'hB6;
      4'd6:    cur_enc = 8'hBE;
      4'd7:    cur_enc = 8'hE0;
      4'd8:    cur_enc = 8'hFE;
      4'd9:    cur_enc = 8'hE6;
      default: cur_enc = 8'h9E;
    endcase
    cur_enc = cur_enc | {7'b0, dp_sh[idx]};
    dark    = blank_sh[idx] | (blink_sh[idx] & ~phase) | supp[idx];
  end

  // Shadow registers capture all data inputs on load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_sh   <= '0;
      dp_sh    <= '0;
      blank_sh <= '0;
      blink_sh <= '0;
      lz_sh    <= 1'b0;
    end else if (load) begin
      dig_sh   <= digits_in;
      dp_sh    <= dp_in;
      blank_sh <= blank_in;
      blink_sh <= blink_in;
      lz_sh    <= lz_en;
    end
  end

  // Prescaler and digit index; the index advances on every slot tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (tick) begin
      pcnt <= '0;
      idx  <= idx + 3'd1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Blink phase toggles every BLINK_SLOTS slot ticks; phase=1 is visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (tick) begin
      if (bcnt == BW'(BLINK_SLOTS - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // Registered outputs: dark during guard time or when the digit is dark
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '0;
      seg <= '0;
    end else if (in_guard || dark) begin
      an  <= '0;
      seg <= '0;
    end else begin
      an  <= 8'b1 << idx;
      seg <= cur_enc;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a cycle-count based model
// predicts an/seg every cycle, with literal checks pinning key points.
module tb_seg_scan_driver;

  localparam int unsigned SD = 8;
  localparam int unsigned GD = 2;
  localparam int unsigned BS = 8;

  localparam logic [7:0] TAB [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6,
                                      8'hBE, 8'hE0, 8'hFE, 8'hE6, 8'h9E, 8'h9E,
                                      8'h9E, 8'h9E, 8'h9E, 8'h9E};

  logic        clk;
  logic        rst;
  logic        load;
  logic [31:0] digits_in;
  logic [7:0]  dp_in;
  logic [7:0]  blank_in;
  logic [7:0]  blink_in;
  logic        lz_en;
  logic [7:0]  an;
  logic [7:0]  seg;

  int tests = 0;
  int fails = 0;

  seg_scan_driver #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_SLOTS(BS)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .blink_in(blink_in), .lz_en(lz_en), .an(an), .seg(seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: edges since reset plus the displayed snapshot
  int unsigned cyc;
  logic [31:0] m_dig;
  logic [7:0]  m_dp, m_blank, m_blink;
  logic        m_lz;
  logic [7:0]  exp_an, exp_seg;
  bit          mvalid = 0;

  // Output implied by the elapsed cycle count: slot = cc/SD, position = cc%SD
  function automatic logic [15:0] model_out(input int unsigned cc);
    int unsigned pc, s;
    logic [2:0]  k;
    logic        vis, dark;
    logic [31:0] sh;
    pc   = cc % SD;
    s    = cc / SD;
    k    = 3'(s % 8);
    vis  = ((s / BS) % 2) == 0;
    sh   = m_dig >> (4 * k);
    dark = m_blank[k] | (m_blink[k] & ~vis) | (m_lz & (k != 3'd0) & (sh == 32'd0));
    if (pc < GD || dark) return 16'h0;
    return {8'b1 << k, TAB[sh[3:0]] | {7'b0, m_dp[k]}};
  endfunction

  // Model update: outputs come from state before the edge, loads land at the edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc     <= 0;
      m_dig   <= '0;
      m_dp    <= '0;
      m_blank <= '0;
      m_blink <= '0;
      m_lz    <= 1'b0;
      exp_an  <= '0;
      exp_seg <= '0;
      mvalid  <= 1'b1;
    end else begin
      {exp_an, exp_seg} <= model_out(cyc);
      cyc <= cyc + 1;
      if (load) begin
        m_dig   <= digits_in;
        m_dp    <= dp_in;
        m_blank <= blank_in;
        m_blink <= blink_in;
        m_lz    <= lz_en;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst && mvalid) begin
      check("an_cycle", 32'(an), 32'(exp_an));
      check("seg_cycle", 32'(seg), 32'(exp_seg));
    end
  end

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl,
                         input logic [7:0] bk, input logic lz);
    digits_in = d;
    dp_in     = dp;
    blank_in  = bl;
    blink_in  = bk;
    lz_en     = lz;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  // Wait (bounded) for digit k to light, then check its segments
  task automatic wait_digit(input int k, input logic [7:0] exp_seg_l, input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (an == (8'b1 << k)) break;
    end
    check({name, "_an"}, 32'(an), 32'(8'b1 << k));
    check({name, "_seg"}, 32'(seg), 32'(exp_seg_l));
  endtask

  int cnt0, cnt7, hits;

  initial begin
    rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0;
    blank_in = '0; blink_in = '0; lz_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_an", 32'(an), 32'h0);
    check("reset_seg", 32'(seg), 32'h0);

    // Test 1: first slot timing and full scan
    rst = 1'b0;
    digits_in = 32'h76543210;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("guard_an", 32'(an), 32'h0);
    repeat (2) @(negedge clk);
    check("slot0_an", 32'(an), 32'h01);
    check("slot0_seg", 32'(seg), 32'hFC);
    repeat (8) @(negedge clk);
    check("slot1_an", 32'(an), 32'h02);
    check("slot1_seg", 32'(seg), 32'h60);
    repeat (48) @(negedge clk);
    check("slot7_an", 32'(an), 32'h80);
    check("slot7_seg", 32'(seg), 32'hE0);
    repeat (8) @(negedge clk);
    check("wrap_an", 32'(an), 32'h01);
    check("wrap_seg", 32'(seg), 32'hFC);

    // Test 2: invalid codes and decimal point
    do_load(32'h000000FA, 8'h01, 8'h00, 8'h00, 1'b0);
    wait_digit(0, 8'h9F, "inv_dp_d0");
    wait_digit(1, 8'h9E, "inv_d1");

    // Test 3: leading-zero suppression
    do_load(32'h00000105, 8'h00, 8'h00, 8'h00, 1'b1);
    wait_digit(0, 8'hB6, "lz_d0");
    wait_digit(1, 8'hFC, "lz_d1");
    wait_digit(2, 8'h60, "lz_d2");
    hits = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ((an & 8'hF8) != 8'h00) hits++;
    end
    check("lz_upper_dark", 32'(hits), 32'd0);
    do_load(32'h00000000, 8'h00, 8'h00, 8'h00, 1'b1);
    wait_digit(0, 8'hFC, "lz_zero_d0");
    hits = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ((an & 8'hFE) != 8'h00) hits++;
    end
    check("lz_zero_only_d0", 32'(hits), 32'd0);

    // Test 4: blink and blank over four whole blink periods
    do_load(32'h76543210, 8'h00, 8'h80, 8'h01, 1'b0);
    cnt0 = 0; cnt7 = 0;
    for (int i = 0; i < 4 * 2 * BS * SD; i++) begin
      @(negedge clk);
      if (an == 8'h01) cnt0++;
      if (an[7]) cnt7++;
    end
    check("blink_d0_lit_cycles", 32'(cnt0), 32'd24);
    check("blank_d7_never", 32'(cnt7), 32'd0);

    // Test 5: mid-slot load, then asynchronous reset mid-cycle
    do_load(32'h76543210, 8'h00, 8'h00, 8'h00, 1'b0);
    wait_digit(0, 8'hFC, "pre_mid");
    do_load(32'h76543218, 8'h00, 8'h00, 8'h00, 1'b0);
    check("mid_edge1_an", 32'(an), 32'h01);
    check("mid_edge1_seg", 32'(seg), 32'hFC);
    @(negedge clk);
    check("mid_edge2_an", 32'(an), 32'h01);
    check("mid_edge2_seg", 32'(seg), 32'hFE);
    #1 rst = 1'b1;
    #1;
    check("async_rst_an", 32'(an), 32'h0);
    check("async_rst_seg", 32'(seg), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_load(32'h76543210, 8'h00, 8'h00, 8'h00, 1'b0);
    wait_digit(3, 8'hF2, "post_rst_d3");

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
